line_buffer_ctrl: RTL and testbench
===================================

Name: line_buffer_ctrl

Overview:
- Sequences the single-port shift_32 line memory (write_en/addr/wr_data/rd_data) as a circular two-line pixel history for the edge detector.
- Per accepted input word it reads the words one line and two lines back, then overwrites the oldest slot.
- Emits a 3-row pixel column (current, -1 line, -2 lines) to the downstream 3x3 convolution stage over a valid/ready handshake.

Parameters:
- DATA_W, 32, pixel word width; matches shift_32 data ports.
- ADDR_W, 7, memory address width.
- DEPTH, 72, number of memory words used; must be <= 2**ADDR_W and >= 2*LINE_LEN.
- LINE_LEN, 36, words per image line.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle pulse; clears history pointer and fill count.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_W  input pixel word.
- out_valid  out  1  column output valid.
- out_ready  in  1  downstream accepts column.
- out_row0  out  DATA_W  current word.
- out_row1  out  DATA_W  word written LINE_LEN words earlier (0 if not yet filled).
- out_row2  out  DATA_W  word written 2*LINE_LEN words earlier (0 if not yet filled).
- out_primed  out  1  out_row2 holds real history.
- mem_write_en  out  1  to shift_32 write_en.
- mem_addr  out  ADDR_W  to shift_32 addr.
- mem_wr_data  out  DATA_W  to shift_32 wr_data.
- mem_rd_data  in  DATA_W  from shift_32 rd_data.

Behaviour:
- Memory contract: mem_rd_data shows the word at the address presented in the previous cycle (1-cycle read latency); a write commits at the rising edge while mem_write_en=1.
- Reset (async, rst=1): state=IDLE, wr_ptr=0, fill=0, pending_clear=0, all data outputs 0, out_valid=0, out_primed=0, mem_write_en=0, mem_addr=0, mem_wr_data=0. in_ready is 0 while rst=1.
- Reset mid-operation: drops any in-flight word and output; no write is issued after rst rises.
- Addresses: A1=(wr_ptr+DEPTH-LINE_LEN) mod DEPTH; A2=(wr_ptr+DEPTH-2*LINE_LEN) mod DEPTH. A2 may equal wr_ptr, so the read must precede the write.
- FSM states and transitions:
  - IDLE: in_ready=1 (unless a clear is applied this cycle). On in_valid&in_ready: latch in_data, go to RD1.
  - RD1: mem_addr=A1, mem_write_en=0. Go to RD2.
  - RD2: mem_addr=A2. Capture mem_rd_data as tap1. Go to WR.
  - WR: mem_addr=wr_ptr, mem_wr_data=latched word, mem_write_en=1. Capture mem_rd_data as tap2. wr_ptr <= (wr_ptr==DEPTH-1)?0:wr_ptr+1. fill <= min(fill+1, 2*LINE_LEN). Go to OUT.
  - OUT: out_valid=1; outputs hold stable until out_ready=1, then go to IDLE.
- Output masking (fill sampled before the increment):
  - out_row1 = tap1 if fill>=LINE_LEN, else 0.
  - out_row2 = tap2 if fill>=2*LINE_LEN, else 0.
  - out_primed = (fill>=2*LINE_LEN).
- Timing: accept-to-out_valid latency is 4 cycles. Maximum throughput is 1 word per 5 cycles with out_ready held high.
- mem_write_en is asserted only in WR, exactly once per accepted word.
- frame_start:
  - In IDLE: wr_ptr=0 and fill=0 on the next edge; in_ready=0 that cycle, so no accept.
  - In any other state: sets pending_clear. The current word completes normally; the clear applies on the next IDLE cycle, with in_ready=0 in that cycle.
- Memory contents are never cleared; masking is driven by fill only.

Test Plan:
- Reset then stream words 1..36 with out_ready=1 -> each column has row0=N, row1=0, row2=0, out_primed=0. Writes land at addr 0..35. Out_valid rises 4 cycles after each accept.
- Continue words 37..72 -> word 37 gives row1=1, row2=0; word 72 gives row1=36, row2=0, out_primed=0.
- Word 73 -> row1=37, row2=1, out_primed=1, written at addr 0 (wrap). Word 110 -> row1=74, row2=38, written at addr 37.
- Hold out_ready=0 for 10 cycles on word 40 -> out_valid stays 1, outputs stable, in_ready=0, no mem_write_en. Release -> IDLE, next word accepted.
- After 80 words, pulse frame_start during RD2 -> word completes with correct taps. The next IDLE cycle has in_ready=0. The following word writes addr 0 with row1=0, row2=0, out_primed=0.
- Assert rst during WR -> mem_write_en drops immediately, out_valid=0. After release, the first word writes addr 0 with fill restarted.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences a single-port line memory as a two-line circular pixel
// history and emits 3-row pixel columns over a valid/ready handshake.
module line_buffer_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 72,
    parameter int LINE_LEN = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_row0,
    output logic [DATA_W-1:0] out_row1,
    output logic [DATA_W-1:0] out_row2,
    output logic              out_primed,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);
    localparam int FILL_W = $clog2(2 * LINE_LEN + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] OFF1    = ADDR_W'(LINE_LEN);
    localparam logic [ADDR_W-1:0] OFF2    = ADDR_W'((2 * LINE_LEN) % DEPTH);
    localparam logic [FILL_W-1:0] HALF    = FILL_W'(LINE_LEN);
    localparam logic [FILL_W-1:0] FULL    = FILL_W'(2 * LINE_LEN);

    typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_WR, S_OUT} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_wr_ptr, w_a1, w_a2;
    logic [FILL_W-1:0] r_fill;
    logic              r_pending_clear, w_clear, w_accept;
    logic [DATA_W-1:0] r_data, r_row1, r_row2;
    logic              r_primed;

    // modular subtraction; DEPTH_A may wrap to 0 when DEPTH == 2**ADDR_W, which stays correct mod 2**ADDR_W
    assign w_a1 = (r_wr_ptr >= OFF1) ? r_wr_ptr - OFF1 : r_wr_ptr + DEPTH_A - OFF1;
    assign w_a2 = (r_wr_ptr >= OFF2) ? r_wr_ptr - OFF2 : r_wr_ptr + DEPTH_A - OFF2;

    assign w_clear    = (r_state == S_IDLE) && (frame_start || r_pending_clear);
    assign in_ready   = (r_state == S_IDLE) && !rst && !frame_start && !r_pending_clear;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == S_OUT);
    assign out_row0   = r_data;
    assign out_row1   = r_row1;
    assign out_row2   = r_row2;
    assign out_primed = r_primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        mem_addr     = '0;
        mem_write_en = 1'b0;
        mem_wr_data  = '0;
        unique case (r_state)
            S_IDLE: w_next = w_accept ? S_RD1 : S_IDLE;
            S_RD1: begin
                mem_addr = w_a1;
                w_next   = S_RD2;
            end
            S_RD2: begin
                mem_addr = w_a2;
                w_next   = S_WR;
            end
            S_WR: begin
                mem_addr     = r_wr_ptr;
                mem_write_en = 1'b1;
                mem_wr_data  = r_data;
                w_next       = S_OUT;
            end
            S_OUT:   w_next = out_ready ? S_IDLE : S_OUT;
            default: w_next = S_IDLE;
        endcase
    end

    // taps are captured one cycle after their address is presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_fill          <= '0;
            r_pending_clear <= 1'b0;
            r_data          <= '0;
            r_row1          <= '0;
            r_row2          <= '0;
            r_primed        <= 1'b0;
        end else begin
            if (w_accept) r_data <= in_data;
            if (r_state == S_RD2) r_row1 <= (r_fill >= HALF) ? mem_rd_data : '0;
            if (r_state == S_WR) begin
                r_row2   <= (r_fill >= FULL) ? mem_rd_data : '0;
                r_primed <= (r_fill >= FULL);
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
                r_fill   <= (r_fill == FULL) ? r_fill : r_fill + 1'b1;
            end
            if (w_clear) begin
                r_wr_ptr        <= '0;
                r_fill          <= '0;
                r_pending_clear <= 1'b0;
            end else if (frame_start && r_state != S_IDLE) begin
                r_pending_clear <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: drives line_buffer_ctrl against a behavioural memory and a
// history-queue reference model of the two-line pixel buffer.
module tb_line_buffer_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_row0, out_row1, out_row2;
    logic        out_primed;
    logic        mem_write_en;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data = '0;
    logic [31:0] mem [0:127];
    logic [31:0] hist[$];
    int          n_cmp = 0;
    int          n_err = 0;

    line_buffer_ctrl dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row0(out_row0), .out_row1(out_row1), .out_row2(out_row2),
        .out_primed(out_primed), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // single-port memory with one-cycle read latency, read-before-write
    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
        if (mem_write_en) mem[mem_addr] <= mem_wr_data;
    end

    // one word through the pipe; model: column = this word plus the words written
    // 36 and 72 accepted words ago since the last clear, zero where not yet written
    task automatic send(input logic [31:0] d, input int hold, input int fs_cycle);
        int n, cv, nw;
        logic [6:0] wa;
        logic [31:0] wd, e1, e2;
        logic ep, got;
        n  = hist.size();
        e1 = (n >= 36) ? hist[n-36] : 32'd0;
        e2 = (n >= 72) ? hist[n-72] : 32'd0;
        ep = (n >= 72);
        @(negedge clk);
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_wait: in_ready=%b required 1", in_ready); end
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = (hold == 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = $urandom;
        cv = 0; nw = 0; got = 1'b0; wa = '0; wd = '0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            frame_start = (c == fs_cycle);
            if (mem_write_en) begin nw++; wa = mem_addr; wd = mem_wr_data; end
            if (out_valid) begin got = 1'b1; cv = c; end
        end
        frame_start = 1'b0;
        n_cmp++;
        if (cv != 4) begin n_err++; $display("FAIL latency: got %0d cycles required 4", cv); end
        n_cmp++;
        if (nw != 1) begin n_err++; $display("FAIL write_count: got %0d required 1", nw); end
        n_cmp++;
        if (wa !== 7'(n % 72)) begin n_err++; $display("FAIL write_addr: got %0d required %0d", wa, n % 72); end
        n_cmp++;
        if (wd !== d) begin n_err++; $display("FAIL write_data: got %h required %h", wd, d); end
        n_cmp++;
        if (out_row0 !== d) begin n_err++; $display("FAIL row0: got %h required %h", out_row0, d); end
        n_cmp++;
        if (out_row1 !== e1) begin n_err++; $display("FAIL row1: got %h required %h (n=%0d)", out_row1, e1, n); end
        n_cmp++;
        if (out_row2 !== e2) begin n_err++; $display("FAIL row2: got %h required %h (n=%0d)", out_row2, e2, n); end
        n_cmp++;
        if (out_primed !== ep) begin n_err++; $display("FAIL primed: got %b required %b", out_primed, ep); end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || mem_write_en !== 1'b0 ||
                out_row0 !== d || out_row1 !== e1 || out_row2 !== e2)
            begin
                n_err++;
                $display("FAIL hold: valid=%b ready=%b we=%b r0=%h r1=%h r2=%h required 1 0 0 %h %h %h",
                         out_valid, in_ready, mem_write_en, out_row0, out_row1, out_row2, d, e1, e2);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        hist.push_back(d);
        if (fs_cycle > 0) hist.delete();
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, mem_write_en, out_primed} !== 4'b0 ||
            {out_row0, out_row1, out_row2, mem_wr_data} !== 128'd0 || mem_addr !== 7'd0)
        begin
            n_err++;
            $display("FAIL reset_state: valid=%b ready=%b we=%b primed=%b addr=%0d required all zero",
                     out_valid, in_ready, mem_write_en, out_primed, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %b required 1", in_ready); end
    endtask

    task automatic test_fill_and_wrap;
        for (int w = 1; w <= 110; w++) send(32'(w), (w == 40) ? 10 : 0, 0);
    endtask

    task automatic test_frame_start_busy;
        send($urandom, 0, 2);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL pending_clear_ready: got %b required 0", in_ready); end
        send($urandom, 0, 0);
        for (int i = 0; i < 5; i++) send($urandom, 0, 0);
    endtask

    task automatic test_frame_start_idle;
        for (int i = 0; i < 40; i++) send($urandom, 0, 0);
        @(negedge clk);
        frame_start = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL idle_clear_ready: got %b required 0", in_ready); end
        @(negedge clk);
        frame_start = 1'b0;
        hist.delete();
        send($urandom, 0, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 120; i++) send($urandom, $urandom_range(0, 3), 0);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = $urandom;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mem_write_en !== 1'b1) begin n_err++; $display("FAIL wr_state: we=%b required 1", mem_write_en); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_write_en !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: we=%b valid=%b ready=%b required 0 0 0", mem_write_en, out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        for (int i = 0; i < 40; i++) send($urandom, 0, 0);
    endtask

    initial begin
        test_reset;
        test_fill_and_wrap;
        test_frame_start_busy;
        test_frame_start_idle;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
